// File: rtl/vfc_pkg.sv
// rtl/vfc_pkg.sv - shared FSM states, default constants and period helper for vfc_gen
package vfc_pkg;

    localparam int DEF_WIDTH      = 12;
    localparam int DEF_MIN_PERIOD = 2;
    localparam int DEF_ADC_DIV    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Period is one longer than the code so a full-scale code still fits; tiny periods are clamped.
    function automatic logic [DEF_WIDTH:0] period_of(input logic [DEF_WIDTH-1:0] code,
                                                    input logic [DEF_WIDTH:0]   min_period);
        logic [DEF_WIDTH:0] p;
        p = {1'b0, code} + {{DEF_WIDTH{1'b0}}, 1'b1};
        if (p < min_period) begin
            p = min_period;
        end
        return p;
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// rtl/adc_clk_div.sv - free-running 50% duty divider producing the ADC conversion clock
module adc_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic CR,
    output logic adc_CP
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_cp;

    always_ff @(posedge clk) begin
        if (CR) begin
            r_cnt <= '0;
            r_cp  <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_cp  <= ~r_cp;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign adc_CP = r_cp;

endmodule

// File: rtl/vfc_gen.sv
// rtl/vfc_gen.sv - code-to-frequency generator with glitch-free period updates and ADC clock
// Build option SQUARE_OUT_EN: square output instead of a single-cycle pulse per period.
module vfc_gen
    import vfc_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int ADC_DIV    = DEF_ADC_DIV
) (
    input  logic             clk,
    input  logic             CR,
    input  logic [WIDTH-1:0] code,
    input  logic             code_valid,
    output logic             code_ready,
    input  logic             en,
    output logic             signal,
    output logic             period_done,
    output logic             adc_CP
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t             r_state;
    logic [WIDTH:0]     r_cnt;
    logic [WIDTH-1:0]   r_active;
    logic [WIDTH-1:0]   r_pending;
    logic               r_pending_valid;
    logic               r_signal;
    logic               r_period_done;

    logic [DEF_WIDTH:0] w_period_full;
    logic [WIDTH:0]     w_period;
    logic [WIDTH:0]     w_last;
    logic               w_boundary;
    logic               w_accept;
    logic               w_high;
    logic [WIDTH-1:0]   w_next_active;

    assign w_period_full = period_of(DEF_WIDTH'(r_active), (DEF_WIDTH + 1)'(MIN_PERIOD));
    assign w_period      = w_period_full[WIDTH:0];
    assign w_last        = w_period - ONE;
    assign w_boundary    = (r_cnt == w_last);
    assign w_accept      = code_valid && !r_pending_valid;
    assign w_next_active = r_pending_valid ? r_pending : r_active;

`ifdef SQUARE_OUT_EN
    logic [WIDTH:0] w_half;
    // Rounding up puts the odd extra cycle in the high phase.
    assign w_half = (w_period + ONE) >> 1;
    assign w_high = (r_cnt < w_half);
`else
    assign w_high = (r_cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (CR) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_active        <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_signal        <= 1'b0;
            r_period_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending       <= code;
                r_pending_valid <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_signal      <= 1'b0;
                    r_period_done <= 1'b0;
                    r_cnt         <= '0;
                    if (r_pending_valid) begin
                        r_active        <= r_pending;
                        r_pending_valid <= 1'b0;
                    end
                    if (en && (r_active != '0)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_signal      <= w_high;
                    r_period_done <= w_boundary;
                    // New codes only take effect at the boundary so no period is ever cut short.
                    if (w_boundary) begin
                        r_cnt <= '0;
                        if (r_pending_valid) begin
                            r_active        <= r_pending;
                            r_pending_valid <= 1'b0;
                        end
                        if (!(en && (w_next_active != '0))) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
            endcase
        end
    end

    assign code_ready  = ~r_pending_valid;
    assign signal      = r_signal;
    assign period_done = r_period_done;

    adc_clk_div #(
        .DIV    (ADC_DIV)
    ) u_adc_clk_div (
        .clk    (clk),
        .CR     (CR),
        .adc_CP (adc_CP)
    );

endmodule
